// File: rtl/vga_wr_arbiter_pkg.sv
// ============================================================================
// Package    : vga_pkg
// Description: Shared types and constants for the video-memory write-port
//              arbiter and its fill engine.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  // Fill engine FSM state
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

  // Source that owns the write port in a given cycle
  typedef enum logic [0:0] {
    SRC_CPU  = 1'b0,
    SRC_FILL = 1'b1
  } gnt_src_t;

  // Fill writes always cover the full 32-bit word
  localparam logic [3:0] VMEM_BYTE_EN_ALL = 4'hF;

endpackage : vga_pkg

`default_nettype wire

// File: rtl/vga_wr_arbiter_if.sv
// ============================================================================
// Interface  : vga_wr_arbiter_if
// Description: Groups the CPU write path, fill command/status and the VGA
//              write port of the video-memory write arbiter.
//              master = bus bridge / controller side, slave = arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_wr_arbiter_if #(
  parameter int VMEM_ADDR_WIDTH = 32,
  parameter int FILL_LEN_WIDTH  = 17
) ();

  // CPU MMIO write path
  logic                       cpu_w_valid;
  logic                       cpu_w_ready;
  logic [VMEM_ADDR_WIDTH-1:0] cpu_w_addr;
  logic [3:0]                 cpu_w_byte_en;
  logic [31:0]                cpu_w_data;

  // Fill command and status
  logic                       fill_start;
  logic [VMEM_ADDR_WIDTH-1:0] fill_base;
  logic [FILL_LEN_WIDTH-1:0]  fill_len;
  logic [31:0]                fill_pattern;
  logic                       fill_busy;
  logic                       fill_done;

  // Write port toward the VGA controller
  logic                       vga_w_en;
  logic [VMEM_ADDR_WIDTH-1:0] vga_w_addr;
  logic [3:0]                 vga_w_byte_en;
  logic [31:0]                vga_w_data;

  modport master (
    output cpu_w_valid, cpu_w_addr, cpu_w_byte_en, cpu_w_data,
    output fill_start, fill_base, fill_len, fill_pattern,
    input  cpu_w_ready, fill_busy, fill_done,
    input  vga_w_en, vga_w_addr, vga_w_byte_en, vga_w_data
  );

  modport slave (
    input  cpu_w_valid, cpu_w_addr, cpu_w_byte_en, cpu_w_data,
    input  fill_start, fill_base, fill_len, fill_pattern,
    output cpu_w_ready, fill_busy, fill_done,
    output vga_w_en, vga_w_addr, vga_w_byte_en, vga_w_data
  );

endinterface : vga_wr_arbiter_if

`default_nettype wire

// File: rtl/vga_fill_engine.sv
// ============================================================================
// Module     : vga_fill_engine
// Description: Hardware fill engine. Walks a contiguous word range writing a
//              constant pattern, one word per grant from the arbiter.
//              Tracks current address, remaining words, busy and done.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fill_engine
  import vga_pkg::*;
#(
  parameter int VMEM_ADDR_WIDTH = 32,
  parameter int FILL_LEN_WIDTH  = 17
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       i_fill_start,
  input  wire logic [VMEM_ADDR_WIDTH-1:0] i_fill_base,
  input  wire logic [FILL_LEN_WIDTH-1:0]  i_fill_len,
  input  wire logic [31:0]                i_fill_pattern,
  input  wire logic                       i_fill_gnt,
  output logic                            o_fill_req,
  output logic      [VMEM_ADDR_WIDTH-1:0] o_fill_addr,
  output logic      [31:0]                o_fill_data,
  output logic                            o_fill_busy,
  output logic                            o_fill_done
);

  fill_state_t                r_state;
  fill_state_t                w_next_state;
  logic [VMEM_ADDR_WIDTH-1:0] r_addr;
  logic [FILL_LEN_WIDTH-1:0]  r_remain;
  logic [31:0]                r_pattern;
  logic                       r_done;

  logic                       w_idle;
  logic                       w_start_ok;
  logic                       w_start_zero;
  logic                       w_last;
  logic [VMEM_ADDR_WIDTH-1:0] w_base_aligned;

  // Masking keeps every base bit in the logic cone; low 2 bits forced to 0
  assign w_base_aligned = i_fill_base & ~VMEM_ADDR_WIDTH'(3);
  assign w_idle         = (r_state == ST_IDLE);
  assign w_start_ok     = w_idle && i_fill_start && (i_fill_len != '0);
  assign w_start_zero   = w_idle && i_fill_start && (i_fill_len == '0);
  assign w_last         = i_fill_gnt && (r_remain == FILL_LEN_WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state: start on a non-empty command, leave after the last grant
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start_ok) w_next_state = ST_FILL;
      ST_FILL: if (w_last)     w_next_state = ST_IDLE;
      default:                 w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: request and busy for the whole FILL phase
  always_comb begin
    o_fill_req  = 1'b0;
    o_fill_busy = 1'b0;
    if (r_state == ST_FILL) begin
      o_fill_req  = 1'b1;
      o_fill_busy = 1'b1;
    end
  end

  // Address/count/pattern: load on start, step once per grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr    <= '0;
      r_remain  <= '0;
      r_pattern <= '0;
    end else if (w_start_ok) begin
      r_addr    <= w_base_aligned;
      r_remain  <= i_fill_len;
      r_pattern <= i_fill_pattern;
    end else if (i_fill_gnt) begin
      r_addr    <= r_addr + VMEM_ADDR_WIDTH'(4);
      r_remain  <= r_remain - FILL_LEN_WIDTH'(1);
    end
  end

  // Done pulse lines up with the last word leaving the output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_done <= 1'b0;
    else        r_done <= w_start_zero || w_last;
  end

  assign o_fill_addr = r_addr;
  assign o_fill_data = r_pattern;
  assign o_fill_done = r_done;

endmodule : vga_fill_engine

`default_nettype wire

// File: rtl/vga_wr_arbiter.sv
// ============================================================================
// Module     : vga_wr_arbiter
// Description: Shares the VGA controller write port between CPU MMIO writes
//              and the fill engine; one registered write per cycle.
//              Macro VGA_WR_ARB_RR_EN: round-robin on contention when defined,
//              fixed CPU priority otherwise.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_wr_arbiter
  import vga_pkg::*;
#(
  parameter int VMEM_ADDR_WIDTH = 32,
  parameter int FILL_LEN_WIDTH  = 17
) (
  input wire logic         clk,
  input wire logic         reset,
  vga_wr_arbiter_if.slave  bus
);

  logic                       w_fill_req;
  logic                       w_fill_gnt;
  logic [VMEM_ADDR_WIDTH-1:0] w_fill_addr;
  logic [31:0]                w_fill_data;
  logic                       w_cpu_pri;
  logic                       w_cpu_ready;
  logic                       w_cpu_gnt;

  logic                       r_vga_en;
  logic [VMEM_ADDR_WIDTH-1:0] r_vga_addr;
  logic [3:0]                 r_vga_byte_en;
  logic [31:0]                r_vga_data;

  vga_fill_engine #(
    .VMEM_ADDR_WIDTH (VMEM_ADDR_WIDTH),
    .FILL_LEN_WIDTH  (FILL_LEN_WIDTH)
  ) u_fill (
    .clk            (clk),
    .reset          (reset),
    .i_fill_start   (bus.fill_start),
    .i_fill_base    (bus.fill_base),
    .i_fill_len     (bus.fill_len),
    .i_fill_pattern (bus.fill_pattern),
    .i_fill_gnt     (w_fill_gnt),
    .o_fill_req     (w_fill_req),
    .o_fill_addr    (w_fill_addr),
    .o_fill_data    (w_fill_data),
    .o_fill_busy    (bus.fill_busy),
    .o_fill_done    (bus.fill_done)
  );

`ifdef VGA_WR_ARB_RR_EN
  gnt_src_t r_last_src;

  // CPU wins contention only if the fill engine took the previous grant
  assign w_cpu_pri = (r_last_src == SRC_FILL);

  // Round-robin pointer: remembers the most recently granted source
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_last_src <= SRC_FILL;
    else if (w_cpu_gnt)  r_last_src <= SRC_CPU;
    else if (w_fill_gnt) r_last_src <= SRC_FILL;
  end
`else
  assign w_cpu_pri = 1'b1;
`endif

  // Ready may float high without valid only while the fill engine is quiet;
  // held low in reset so nothing is accepted before the port is live
  assign w_cpu_ready = reset && (!w_fill_req || (bus.cpu_w_valid && w_cpu_pri));
  assign w_cpu_gnt   = bus.cpu_w_valid && w_cpu_ready;
  assign w_fill_gnt  = w_fill_req && !w_cpu_gnt;

  // Output register: capture the granted source's write for the next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vga_en      <= 1'b0;
      r_vga_addr    <= '0;
      r_vga_byte_en <= '0;
      r_vga_data    <= '0;
    end else begin
      r_vga_en <= w_cpu_gnt || w_fill_gnt;
      if (w_cpu_gnt) begin
        r_vga_addr    <= bus.cpu_w_addr;
        r_vga_byte_en <= bus.cpu_w_byte_en;
        r_vga_data    <= bus.cpu_w_data;
      end else if (w_fill_gnt) begin
        r_vga_addr    <= w_fill_addr;
        r_vga_byte_en <= VMEM_BYTE_EN_ALL;
        r_vga_data    <= w_fill_data;
      end
    end
  end

  assign bus.cpu_w_ready   = w_cpu_ready;
  assign bus.vga_w_en      = r_vga_en;
  assign bus.vga_w_addr    = r_vga_addr;
  assign bus.vga_w_byte_en = r_vga_byte_en;
  assign bus.vga_w_data    = r_vga_data;

endmodule : vga_wr_arbiter

`default_nettype wire

// File: tb/tb_vga_wr_arbiter.sv
// ============================================================================
// Module     : tb_vga_wr_arbiter
// Description: Directed self-checking bench for vga_wr_arbiter. Expected
//              contention order follows VGA_WR_ARB_RR_EN when defined.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_wr_arbiter;

  logic clk;
  logic reset;
  int   n_total;
  int   n_fail;

  vga_wr_arbiter_if #(.VMEM_ADDR_WIDTH(32), .FILL_LEN_WIDTH(17)) bus ();

  vga_wr_arbiter #(.VMEM_ADDR_WIDTH(32), .FILL_LEN_WIDTH(17)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; registered outputs are stable afterwards
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [31:0] base, input logic [16:0] len,
                            input logic [31:0] pat);
    bus.fill_start   = 1'b1;
    bus.fill_base    = base;
    bus.fill_len     = len;
    bus.fill_pattern = pat;
  endtask

  initial begin
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    logic        exp_rdy [6];
    int          k;
    int          nf;
    int          n_wr;
    int          n_done;
    logic [31:0] last_addr;

    n_total = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus.cpu_w_valid   = 1'b1;
    bus.cpu_w_addr    = 32'h10;
    bus.cpu_w_byte_en = 4'b0011;
    bus.cpu_w_data    = 32'h0000ABCD;
    bus.fill_start    = 1'b0;
    bus.fill_base     = '0;
    bus.fill_len      = '0;
    bus.fill_pattern  = '0;

    // Reset held with CPU requesting
    repeat (3) step();
    chk("rst_ready", bus.cpu_w_ready, 0);
    chk("rst_en",    bus.vga_w_en,    0);
    chk("rst_busy",  bus.fill_busy,   0);
    chk("rst_done",  bus.fill_done,   0);

    // Release reset; the pending CPU write goes first
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("cpu_ready", bus.cpu_w_ready, 1);
    step();
    bus.cpu_w_valid = 1'b0;
    chk("cpu_en",   bus.vga_w_en,      1);
    chk("cpu_addr", bus.vga_w_addr,    32'h10);
    chk("cpu_be",   bus.vga_w_byte_en, 4'b0011);
    chk("cpu_data", bus.vga_w_data,    32'h0000ABCD);
    step();
    chk("cpu_en_off", bus.vga_w_en, 0);

    // Plain fill of 4 words from an unaligned base
    start_fill(32'h102, 17'd4, 32'h0F0F0F0F);
    step();
    bus.fill_start = 1'b0;
    chk("fill_busy1", bus.fill_busy, 1);
    chk("fill_en1",   bus.vga_w_en,  0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_en",   bus.vga_w_en,      1);
      chk("fill_addr", bus.vga_w_addr,    32'h100 + 32'(4 * i));
      chk("fill_be",   bus.vga_w_byte_en, 4'hF);
      chk("fill_data", bus.vga_w_data,    32'h0F0F0F0F);
      chk("fill_done", bus.fill_done,     (i == 3) ? 1 : 0);
      chk("fill_busy", bus.fill_busy,     (i == 3) ? 0 : 1);
    end
    step();
    chk("fill_en_end",   bus.vga_w_en,  0);
    chk("fill_done_end", bus.fill_done, 0);

    // Contention: fill len 3 vs CPU valid for 6 cycles
`ifdef VGA_WR_ARB_RR_EN
    exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    start_fill(32'h200, 17'd3, 32'hF1F1F1F1);
    step();
    bus.fill_start = 1'b0;
    k  = 0;
    nf = 0;
    for (int c = 0; c < 6; c++) begin
      bus.cpu_w_valid   = 1'b1;
      bus.cpu_w_addr    = 32'h300 + 32'(4 * k);
      bus.cpu_w_byte_en = 4'h5;
      bus.cpu_w_data    = 32'hC0DE0000 + 32'(k);
      #1;
      chk("cont_ready", bus.cpu_w_ready, exp_rdy[c]);
      if (exp_rdy[c]) begin
        exp_data = 32'hC0DE0000 + 32'(k);
        exp_addr = 32'h300 + 32'(4 * k);
        k++;
      end else begin
        exp_data = 32'hF1F1F1F1;
        exp_addr = 32'h200 + 32'(4 * nf);
        nf++;
      end
      step();
      chk("cont_en",   bus.vga_w_en,   1);
      chk("cont_data", bus.vga_w_data, exp_data);
      chk("cont_addr", bus.vga_w_addr, exp_addr);
      chk("cont_done", bus.fill_done,  (!exp_rdy[c] && nf == 3) ? 1 : 0);
    end
    bus.cpu_w_valid = 1'b0;
`ifndef VGA_WR_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cont_fen",   bus.vga_w_en,   1);
      chk("cont_fdata", bus.vga_w_data, 32'hF1F1F1F1);
      chk("cont_faddr", bus.vga_w_addr, 32'h200 + 32'(4 * i));
      chk("cont_fdone", bus.fill_done,  (i == 2) ? 1 : 0);
    end
`endif
    step();
    chk("cont_idle_en", bus.vga_w_en,  0);
    chk("cont_busy",    bus.fill_busy, 0);

    // Zero-length fill
    start_fill(32'h600, 17'd0, 32'h12345678);
    step();
    bus.fill_start = 1'b0;
    chk("zero_done", bus.fill_done, 1);
    chk("zero_busy", bus.fill_busy, 0);
    chk("zero_en",   bus.vga_w_en,  0);
    step();
    chk("zero_done2", bus.fill_done, 0);
    chk("zero_en2",   bus.vga_w_en,  0);

    // Len-8 fill with a second start mid-way that must be ignored
    start_fill(32'h400, 17'd8, 32'hAAAA5555);
    step();
    bus.fill_start = 1'b0;
    n_wr      = 0;
    n_done    = 0;
    last_addr = '0;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) start_fill(32'h800, 17'd2, 32'h11111111);
      if (c == 3) bus.fill_start = 1'b0;
      step();
      if (bus.vga_w_en) begin
        n_wr++;
        last_addr = bus.vga_w_addr;
      end
      if (bus.fill_done) n_done++;
    end
    chk("ign_writes", n_wr,      8);
    chk("ign_dones",  n_done,    1);
    chk("ign_last",   last_addr, 32'h41C);
    chk("ign_busy",   bus.fill_busy, 0);

    // Reset after 2 of 5 words aborts the fill silently
    start_fill(32'h500, 17'd5, 32'h5A5A5A5A);
    step();
    bus.fill_start = 1'b0;
    step();
    chk("abort_w1", bus.vga_w_addr, 32'h500);
    step();
    chk("abort_w2", bus.vga_w_addr, 32'h504);
    reset = 1'b0;
    #1;
    chk("abort_en",   bus.vga_w_en,   0);
    chk("abort_busy", bus.fill_busy,  0);
    chk("abort_done", bus.fill_done,  0);
    chk("abort_addr", bus.vga_w_addr, 0);
    step();
    step();
    reset  = 1'b1;
    n_wr   = 0;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.vga_w_en)  n_wr++;
      if (bus.fill_done) n_done++;
    end
    chk("abort_nowr",   n_wr,   0);
    chk("abort_nodone", n_done, 0);

    // Address wrap at the top of the space
    start_fill(32'hFFFFFFFC, 17'd2, 32'hDEADBEEF);
    step();
    bus.fill_start = 1'b0;
    step();
    chk("wrap_addr0", bus.vga_w_addr, 32'hFFFFFFFC);
    chk("wrap_en0",   bus.vga_w_en,   1);
    step();
    chk("wrap_addr1", bus.vga_w_addr, 32'h00000000);
    chk("wrap_done",  bus.fill_done,  1);
    step();
    chk("wrap_end",   bus.vga_w_en,   0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule : tb_vga_wr_arbiter

`default_nettype wire
